// File: rtl/alu_exec_stage.sv
// ---------------------------------------------------------------------------
// alu_exec_stage
//   Decode/execute slice of the small 8-bit CPU. The 3-bit opcode is decoded
//   into control flags. The flags, the immediate and both register-file read
//   operands are held for one pipeline stage. In the following cycle the ALU
//   result, or the synchronised switch value, is presented as register-file
//   write data. The last ALU result is also kept on a registered output port.
//
// Optional feature:
//   ALU_SAT_ADD_EN  defined   -> adds clamp to 2^BUS_WIDTH-1 on overflow
//                   undefined -> adds wrap modulo 2^BUS_WIDTH (default)
//
// Ports:
//   i_clk         rising-edge clock
//   i_reset       synchronous, active-high reset
//   i_opcode      instr[11:9]
//   i_imm         instr[7:0], immediate
//   i_wr_addr_in  instr[7:6], destination register
//   i_data_a      register-file read port A
//   i_data_b      register-file read port B
//   i_sw_data     synchronised input-switch value
//   o_f_wait      combinational wait flag of the present opcode
//   o_we          registered register-file write enable
//   o_wr_addr     registered destination address
//   o_wr_data     write data, combinational from the stage registers
//   o_out_port    registered last ALU result
// ---------------------------------------------------------------------------
module alu_exec_stage #(
  parameter int BUS_WIDTH      = 8,
  parameter int OPCODE_WIDTH   = 3,
  parameter int REG_ADDR_WIDTH = 2
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [OPCODE_WIDTH-1:0]   i_opcode,
  input  logic [BUS_WIDTH-1:0]      i_imm,
  input  logic [REG_ADDR_WIDTH-1:0] i_wr_addr_in,
  input  logic [BUS_WIDTH-1:0]      i_data_a,
  input  logic [BUS_WIDTH-1:0]      i_data_b,
  input  logic [BUS_WIDTH-1:0]      i_sw_data,
  output logic                      o_f_wait,
  output logic                      o_we,
  output logic [REG_ADDR_WIDTH-1:0] o_wr_addr,
  output logic [BUS_WIDTH-1:0]      o_wr_data,
  output logic [BUS_WIDTH-1:0]      o_out_port
);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_WAIT = 3'b001;
  localparam logic [2:0] OP_IN   = 3'b010;
  localparam logic [2:0] OP_LDI  = 3'b011;
  localparam logic [2:0] OP_MOV  = 3'b100;
  localparam logic [2:0] OP_ADD  = 3'b101;
  localparam logic [2:0] OP_ADDI = 3'b110;
  localparam logic [2:0] OP_OR   = 3'b111;

  // Decoder outputs; reg_en bit 0 selects A, bit 1 selects B, bit 2 the immediate.
  logic       w_f_add;
  logic       w_f_wait;
  logic       w_f_load;
  logic       w_wr_res;
  logic [2:0] w_reg_en;

  // Stage registers
  logic [BUS_WIDTH-1:0]      r_op_a;
  logic [BUS_WIDTH-1:0]      r_op_b;
  logic [BUS_WIDTH-1:0]      r_op_imm;
  logic                      r_add;
  logic                      r_load;
  logic [2:0]                r_en;
  logic                      r_we;
  logic [REG_ADDR_WIDTH-1:0] r_wr_addr;
  logic [BUS_WIDTH-1:0]      r_out_port;

  // ALU datapath
  logic [BUS_WIDTH-1:0] w_src_a;
  logic [BUS_WIDTH-1:0] w_src_b;
  logic [BUS_WIDTH-1:0] w_src_i;
  logic [BUS_WIDTH-1:0] w_add_res;
  logic [BUS_WIDTH-1:0] w_alu;

  // Opcode decode into control flags
  always_comb begin
    w_f_add  = 1'b0;
    w_f_wait = 1'b0;
    w_f_load = 1'b0;
    w_wr_res = 1'b0;
    w_reg_en = 3'b000;
    case (i_opcode)
      OP_NOP: begin
        w_f_add = 1'b0;
      end
      OP_WAIT: begin
        w_f_wait = 1'b1;
      end
      OP_IN: begin
        w_f_load = 1'b1;
        w_wr_res = 1'b1;
      end
      OP_LDI: begin
        w_reg_en = 3'b100;
        w_wr_res = 1'b1;
      end
      OP_MOV: begin
        w_reg_en = 3'b001;
        w_wr_res = 1'b1;
      end
      OP_ADD: begin
        w_reg_en = 3'b011;
        w_f_add  = 1'b1;
        w_wr_res = 1'b1;
      end
      OP_ADDI: begin
        w_reg_en = 3'b101;
        w_f_add  = 1'b1;
        w_wr_res = 1'b1;
      end
      OP_OR: begin
        w_reg_en = 3'b011;
        w_wr_res = 1'b1;
      end
      default: begin
        w_reg_en = 3'b000;
      end
    endcase
  end

  // Pipeline stage: capture operands and decoded controls every cycle
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_op_a    <= {BUS_WIDTH{1'b0}};
      r_op_b    <= {BUS_WIDTH{1'b0}};
      r_op_imm  <= {BUS_WIDTH{1'b0}};
      r_add     <= 1'b0;
      r_load    <= 1'b0;
      r_en      <= 3'b000;
      r_we      <= 1'b0;
      r_wr_addr <= {REG_ADDR_WIDTH{1'b0}};
    end else begin
      r_op_a    <= i_data_a;
      r_op_b    <= i_data_b;
      r_op_imm  <= i_imm;
      r_add     <= w_f_add;
      r_load    <= w_f_load;
      r_en      <= w_reg_en;
      r_we      <= w_wr_res;
      r_wr_addr <= i_wr_addr_in;
    end
  end

  assign w_src_a = r_en[0] ? r_op_a   : {BUS_WIDTH{1'b0}};
  assign w_src_b = r_en[1] ? r_op_b   : {BUS_WIDTH{1'b0}};
  assign w_src_i = r_en[2] ? r_op_imm : {BUS_WIDTH{1'b0}};

`ifdef ALU_SAT_ADD_EN
  // Two guard bits hold the full sum of three sources so overflow is visible.
  logic [BUS_WIDTH+1:0] w_sum_full;
  assign w_sum_full = {2'b00, w_src_a} + {2'b00, w_src_b} + {2'b00, w_src_i};

  // Clamp the adder result to all-ones on overflow
  always_comb begin
    if (w_sum_full[BUS_WIDTH+1:BUS_WIDTH] != 2'b00) begin
      w_add_res = {BUS_WIDTH{1'b1}};
    end else begin
      w_add_res = w_sum_full[BUS_WIDTH-1:0];
    end
  end
`else
  // Modulo add: the carry out is simply dropped.
  assign w_add_res = w_src_a + w_src_b + w_src_i;
`endif

  // ALU function select: add or bitwise OR of the masked sources
  always_comb begin
    if (r_add) begin
      w_alu = w_add_res;
    end else begin
      w_alu = w_src_a | w_src_b | w_src_i;
    end
  end

  // Output port keeps the last ALU result; instructions with no sources leave it alone
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_out_port <= {BUS_WIDTH{1'b0}};
    end else if (r_en != 3'b000) begin
      r_out_port <= w_alu;
    end else begin
      r_out_port <= r_out_port;
    end
  end

  assign o_f_wait   = w_f_wait;
  assign o_we       = r_we;
  assign o_wr_addr  = r_wr_addr;
  assign o_wr_data  = r_load ? i_sw_data : w_alu;
  assign o_out_port = r_out_port;

endmodule

// File: tb/tb_alu_exec_stage.sv
// ---------------------------------------------------------------------------
// Testbench for alu_exec_stage: directed table of vectors, hand-written reset
// sequences, then randomized instructions against a behavioural model.
// ---------------------------------------------------------------------------
module tb_alu_exec_stage;

`ifdef ALU_SAT_ADD_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct packed {
    logic       rst;
    logic [2:0] op;
    logic [7:0] imm;
    logic [1:0] wa;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sw;
    logic       e_fwait;
    logic       e_we;
    logic [1:0] e_wa;
    logic [7:0] e_wd;
    logic [7:0] e_out;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] opcode;
  logic [7:0] imm;
  logic [1:0] wr_addr_in;
  logic [7:0] data_a;
  logic [7:0] data_b;
  logic [7:0] sw_data;
  logic       f_wait;
  logic       we;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] out_port;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_exec_stage dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_opcode     (opcode),
    .i_imm        (imm),
    .i_wr_addr_in (wr_addr_in),
    .i_data_a     (data_a),
    .i_data_b     (data_b),
    .i_sw_data    (sw_data),
    .o_f_wait     (f_wait),
    .o_we         (we),
    .o_wr_addr    (wr_addr),
    .o_wr_data    (wr_data),
    .o_out_port   (out_port)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  // Drive one instruction, check f_wait in the same cycle, then the stage outputs after the edge.
  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    reset      = v.rst;
    opcode     = v.op;
    imm        = v.imm;
    wr_addr_in = v.wa;
    data_a     = v.a;
    data_b     = v.b;
    sw_data    = v.sw;
    #1;
    chk({tag, " f_wait"}, {7'd0, f_wait}, {7'd0, v.e_fwait});
    @(posedge clk);
    #1;
    chk({tag, " we"},       {7'd0, we},      {7'd0, v.e_we});
    chk({tag, " wr_addr"},  {6'd0, wr_addr}, {6'd0, v.e_wa});
    chk({tag, " wr_data"},  wr_data,         v.e_wd);
    chk({tag, " out_port"}, out_port,        v.e_out);
  endtask

  // Architectural result of an instruction, computed from the instruction's meaning.
  function automatic logic [7:0] ref_result(input logic [2:0] op, input logic [7:0] a,
                                            input logic [7:0] b, input logic [7:0] im,
                                            input logic [7:0] sw);
    int s;
    case (op)
      3'd2: return sw;
      3'd3: return im;
      3'd4: return a;
      3'd5: s = int'(a) + int'(b);
      3'd6: s = int'(a) + int'(im);
      3'd7: return a | b;
      default: return 8'h00;
    endcase
    if (SAT && s > 255) return 8'hFF;
    return 8'(s % 256);
  endfunction

  localparam logic [7:0] R_ADD_FF02 = SAT ? 8'hFF : 8'h01;
  localparam logic [7:0] R_ADD_F020 = SAT ? 8'hFF : 8'h10;
  localparam logic [7:0] R_ADDI_FF1 = SAT ? 8'hFF : 8'h00;

  vec_t vecs [13];
  vec_t v;
  logic [7:0] exp_out;
  logic [7:0] pend_res;
  logic       pend_upd;

  initial begin
    reset = 1'b1; opcode = 3'd0; imm = 8'h00; wr_addr_in = 2'd0;
    data_a = 8'h00; data_b = 8'h00; sw_data = 8'h00;

    //            rst  op    imm    wa    a      b      sw     fw    we    wa    wd          out
    vecs[0]  = '{1'b1, 3'd5, 8'h00, 2'd1, 8'hFF, 8'h02, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00,      8'h00};
    vecs[1]  = '{1'b1, 3'd5, 8'h00, 2'd1, 8'hFF, 8'h02, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00,      8'h00};
    vecs[2]  = '{1'b0, 3'd3, 8'h5A, 2'd2, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 2'd2, 8'h5A,      8'h00};
    vecs[3]  = '{1'b0, 3'd5, 8'h00, 2'd1, 8'hFF, 8'h02, 8'h00, 1'b0, 1'b1, 2'd1, R_ADD_FF02, 8'h5A};
    vecs[4]  = '{1'b0, 3'd6, 8'h22, 2'd3, 8'h10, 8'h99, 8'h00, 1'b0, 1'b1, 2'd3, 8'h32,      R_ADD_FF02};
    vecs[5]  = '{1'b0, 3'd7, 8'h33, 2'd0, 8'h0F, 8'hF0, 8'h00, 1'b0, 1'b1, 2'd0, 8'hFF,      8'h32};
    vecs[6]  = '{1'b0, 3'd4, 8'h55, 2'd1, 8'h3C, 8'hAA, 8'h00, 1'b0, 1'b1, 2'd1, 8'h3C,      8'hFF};
    vecs[7]  = '{1'b0, 3'd2, 8'h56, 2'd2, 8'h12, 8'h34, 8'h77, 1'b0, 1'b1, 2'd2, 8'h77,      8'h3C};
    vecs[8]  = '{1'b0, 3'd1, 8'h9C, 2'd3, 8'h44, 8'h55, 8'h11, 1'b1, 1'b0, 2'd3, 8'h00,      8'h3C};
    vecs[9]  = '{1'b0, 3'd0, 8'h9C, 2'd1, 8'h44, 8'h55, 8'h22, 1'b0, 1'b0, 2'd1, 8'h00,      8'h3C};
    vecs[10] = '{1'b0, 3'd5, 8'h00, 2'd2, 8'hF0, 8'h20, 8'h00, 1'b0, 1'b1, 2'd2, R_ADD_F020, 8'h3C};
    vecs[11] = '{1'b0, 3'd6, 8'h01, 2'd3, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1, 2'd3, R_ADDI_FF1, R_ADD_F020};
    vecs[12] = '{1'b0, 3'd0, 8'h00, 2'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00,      R_ADDI_FF1};

    for (int i = 0; i < 13; i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset while an ADD sits in the stage: its write and out_port update are dropped.
    v = '{1'b0, 3'd5, 8'h00, 2'd1, 8'h11, 8'h22, 8'h00, 1'b0, 1'b1, 2'd1, 8'h33, R_ADDI_FF1};
    apply(v, "pre_rst_add");
    v = '{1'b1, 3'd3, 8'hAB, 2'd2, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00};
    apply(v, "mid_rst");
    v = '{1'b0, 3'd0, 8'h00, 2'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00};
    apply(v, "post_rst_nop");

    // Randomized instruction stream against the model.
    exp_out  = 8'h00;
    pend_res = 8'h00;
    pend_upd = 1'b0;
    for (int n = 0; n < 400; n++) begin
      v.rst = ($urandom_range(0, 31) == 0);
      v.op  = 3'($urandom_range(0, 7));
      v.imm = 8'($urandom);
      v.wa  = 2'($urandom);
      v.a   = 8'($urandom);
      v.b   = 8'($urandom);
      v.sw  = 8'($urandom);
      v.e_fwait = (v.op == 3'd1);
      if (v.rst) begin
        v.e_we   = 1'b0;
        v.e_wa   = 2'd0;
        v.e_wd   = 8'h00;
        v.e_out  = 8'h00;
        pend_upd = 1'b0;
      end else begin
        v.e_out  = pend_upd ? pend_res : exp_out;
        v.e_we   = (v.op >= 3'd2);
        v.e_wa   = v.wa;
        v.e_wd   = ref_result(v.op, v.a, v.b, v.imm, v.sw);
        pend_upd = (v.op >= 3'd3);
        pend_res = v.e_wd;
      end
      exp_out = v.e_out;
      apply(v, $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
